// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the dmem_resp data-memory responder.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (see dmem_resp.sv).
package dmem_pkg;

  // Responder FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bytes per 32-bit word and the resulting byte-offset width inside a word
  localparam int WORD_BYTES = 4;
  localparam int OFF_W      = $clog2(WORD_BYTES);

  // Latency counter width; wide enough for LAT-2 with LAT up to 15
  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 word storage with one synchronous write port and one
// synchronous read port. Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Commit a store or capture a load word on the strobe edge
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wdata;
    end
    if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: single-port data memory responder for the CPU load/store port.
// One request is accepted in IDLE, the memory access happens on the edge that
// enters RESP (LAT cycles after accept), and the response is held until taken.
// Optional feature macro: DMEM_ALIGN_CHECK_EN -- when defined, a byte address
// with nonzero low bits is rejected with resp_err; otherwise the low bits are
// ignored and the containing word is accessed.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int   AW        = $clog2(DEPTH);
  localparam cnt_t WAIT_LOAD = (LAT >= 2) ? cnt_t'(LAT - 2) : '0;

  state_t      state;
  cnt_t        cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rdata_en;
  logic [31:0] arr_rdata;

  logic        accept;
  logic        enter_resp;
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        range_err;
  logic        align_err;
  logic        cur_err;
  logic        arr_wr;
  logic        arr_rd;

  assign accept     = (state == IDLE) && req_valid && req_ready;
  assign enter_resp = ((state == WAIT) && (cnt == '0)) || (accept && (LAT == 1));

  // With LAT=1 the access happens on the accept edge itself, so the request is
  // taken straight from the port in IDLE and from the latch otherwise.
  assign cur_we    = (state == IDLE) ? req_we    : we_q;
  assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;

  // Word index beyond the array is rejected; there is no wrap-around
  assign range_err = 32'(cur_addr[31:OFF_W]) >= 32'(DEPTH);

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = cur_addr[OFF_W-1:0] != '0;
`else
  logic align_unused;
  assign align_err    = 1'b0;
  assign align_unused = ^cur_addr[OFF_W-1:0];
`endif

  assign cur_err = range_err | align_err;
  assign arr_wr  = enter_resp &  cur_we & ~cur_err;
  assign arr_rd  = enter_resp & ~cur_we & ~cur_err;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .wr_en (arr_wr),
    .rd_en (arr_rd),
    .addr  (cur_addr[AW+OFF_W-1:OFF_W]),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

  // The array read register is never reset, so the output is gated by a flag
  // that is only set for a successful load and cleared at reset/handshake.
  assign resp_rdata = rdata_en ? arr_rdata : 32'h0;

  // Request/response FSM with latched request, latency counter and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rdata_en   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (LAT == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= cur_err;
              rdata_en   <= ~cur_we & ~cur_err;
            end else begin
              cnt   <= WAIT_LOAD;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= cur_err;
            rdata_en   <= ~cur_we & ~cur_err;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_valid && resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rdata_en   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed self-checking bench for dmem_resp.
// Instance a uses DEPTH=1024, LAT=2; instance b uses DEPTH=1024, LAT=1.
// Expected values for the misaligned store follow DMEM_ALIGN_CHECK_EN.
module tb_dmem_resp;

  logic        clk;
  logic        rst_n;

  logic        a_req_valid, a_req_ready, a_req_we;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_resp_rdata;

  int errors = 0;
  int checks = 0;

  dmem_resp #(.DEPTH(1024), .LAT(2)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (a_req_valid),
    .req_ready  (a_req_ready),
    .req_we     (a_req_we),
    .req_addr   (a_req_addr),
    .req_wdata  (a_req_wdata),
    .resp_valid (a_resp_valid),
    .resp_ready (a_resp_ready),
    .resp_rdata (a_resp_rdata),
    .resp_err   (a_resp_err)
  );

  dmem_resp #(.DEPTH(1024), .LAT(1)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (b_req_valid),
    .req_ready  (b_req_ready),
    .req_we     (b_req_we),
    .req_addr   (b_req_addr),
    .req_wdata  (b_req_wdata),
    .resp_valid (b_resp_valid),
    .resp_ready (b_resp_ready),
    .resp_rdata (b_resp_rdata),
    .resp_err   (b_resp_err)
  );

  // Free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it before sampling/driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One comparison: count it, and on mismatch count and report the failure
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request to instance a, check latency, hold the response for
  // 'hold' cycles with resp_ready low checking stability, then take it
  task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err, input int hold);
    int n;
    a_req_valid  = 1'b1;
    a_req_we     = we;
    a_req_addr   = addr;
    a_req_wdata  = wdata;
    a_resp_ready = 1'b0;
    checkOutput({tag, ".ready_before"}, 32'(a_req_ready), 32'd1);
    step();
    a_req_valid = 1'b0;
    checkOutput({tag, ".ready_after_accept"}, 32'(a_req_ready), 32'd0);
    n = 1;
    while (!a_resp_valid && n < 20) begin
      step();
      n++;
    end
    checkOutput({tag, ".latency"}, 32'(n), 32'd2);
    for (int i = 0; i <= hold; i++) begin
      checkOutput({tag, ".valid"}, 32'(a_resp_valid), 32'd1);
      checkOutput({tag, ".rdata"}, a_resp_rdata, exp_rdata);
      checkOutput({tag, ".err"}, 32'(a_resp_err), 32'(exp_err));
      checkOutput({tag, ".ready_in_resp"}, 32'(a_req_ready), 32'd0);
      if (i < hold) step();
    end
    a_resp_ready = 1'b1;
    step();
    a_resp_ready = 1'b0;
    checkOutput({tag, ".valid_cleared"}, 32'(a_resp_valid), 32'd0);
    checkOutput({tag, ".ready_restored"}, 32'(a_req_ready), 32'd1);
    checkOutput({tag, ".rdata_cleared"}, a_resp_rdata, 32'h0);
    checkOutput({tag, ".err_cleared"}, 32'(a_resp_err), 32'd0);
  endtask

  logic [31:0] misaligned_err;
  logic [31:0] word10_after;

  logic        b_we_tab   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] b_addr_tab [6] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h0, 32'h2000};
  logic [31:0] b_data_tab [6] = '{32'hCAFEF00D, 32'h0BADC0DE, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] b_exp_tab  [6] = '{32'h0, 32'h0, 32'hCAFEF00D, 32'h0BADC0DE, 32'hCAFEF00D, 32'h0};
  logic        b_err_tab  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
`ifdef DMEM_ALIGN_CHECK_EN
    misaligned_err = 32'd1;
    word10_after   = 32'hDEADBEEF;
`else
    misaligned_err = 32'd0;
    word10_after   = 32'hFFFFFFFF;
`endif

    rst_n        = 1'b0;
    a_req_valid  = 1'b0;
    a_req_we     = 1'b0;
    a_req_addr   = '0;
    a_req_wdata  = '0;
    a_resp_ready = 1'b0;
    b_req_valid  = 1'b0;
    b_req_we     = 1'b0;
    b_req_addr   = '0;
    b_req_wdata  = '0;
    b_resp_ready = 1'b0;

    // Reset state
    step();
    step();
    checkOutput("reset.req_ready", 32'(a_req_ready), 32'd1);
    checkOutput("reset.resp_valid", 32'(a_resp_valid), 32'd0);
    checkOutput("reset.resp_rdata", a_resp_rdata, 32'h0);
    checkOutput("reset.resp_err", 32'(a_resp_err), 32'd0);
    rst_n = 1'b1;
    step();

    // Store then load back the same word
    applyStimulus("st_10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    applyStimulus("ld_10_hold3", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);

    // Range boundary: last word is fine, one past is rejected
    applyStimulus("st_1000_oor", 1'b1, 32'h1000, 32'h5A5A5A5A, 32'h0, 1'b1, 0);
    applyStimulus("st_ffc", 1'b1, 32'hFFC, 32'h12345678, 32'h0, 1'b0, 0);
    applyStimulus("ld_ffc", 1'b0, 32'hFFC, 32'h0, 32'h12345678, 1'b0, 0);
    applyStimulus("ld_fffffffc_oor", 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 1);

    // Misaligned store, then load of the containing word
    applyStimulus("st_13_misaligned", 1'b1, 32'h13, 32'hFFFFFFFF, 32'h0, misaligned_err[0], 0);
    applyStimulus("ld_10_after_misaligned", 1'b0, 32'h10, 32'h0, word10_after, 1'b0, 0);

    // Reset during WAIT discards the pending store
    applyStimulus("st_20_old", 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0, 0);
    a_req_valid = 1'b1;
    a_req_we    = 1'b1;
    a_req_addr  = 32'h20;
    a_req_wdata = 32'hAAAA5555;
    step();
    a_req_valid = 1'b0;
    checkOutput("rst_wait.in_wait_ready", 32'(a_req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_wait.req_ready", 32'(a_req_ready), 32'd1);
    checkOutput("rst_wait.resp_valid", 32'(a_resp_valid), 32'd0);
    checkOutput("rst_wait.resp_rdata", a_resp_rdata, 32'h0);
    checkOutput("rst_wait.resp_err", 32'(a_resp_err), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    applyStimulus("ld_20_after_rst", 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 0);

    // LAT=1 instance: back-to-back requests with resp_ready tied high
    b_resp_ready = 1'b1;
    b_req_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_req_we    = b_we_tab[i];
      b_req_addr  = b_addr_tab[i];
      b_req_wdata = b_data_tab[i];
      checkOutput($sformatf("lat1[%0d].ready_idle", i), 32'(b_req_ready), 32'd1);
      step();
      checkOutput($sformatf("lat1[%0d].valid", i), 32'(b_resp_valid), 32'd1);
      checkOutput($sformatf("lat1[%0d].rdata", i), b_resp_rdata, b_exp_tab[i]);
      checkOutput($sformatf("lat1[%0d].err", i), 32'(b_resp_err), 32'(b_err_tab[i]));
      checkOutput($sformatf("lat1[%0d].ready_busy", i), 32'(b_req_ready), 32'd0);
      step();
      checkOutput($sformatf("lat1[%0d].valid_done", i), 32'(b_resp_valid), 32'd0);
    end
    b_req_valid  = 1'b0;
    b_resp_ready = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Single-port data memory responder serving the CPU's load/store port: it accepts one request (address, write data, write enable) per handshake, commits writes or fetches read words after a fixed latency, and returns a response with read data and an error flag. It sits between the CPU datapath's ALU result / busB outputs and the MemToReg write-back mux.

## Interface
- DEPTH, 1024: number of 32-bit words; power of two, 2..65536
- LAT, 2: cycles from request acceptance to resp_valid; 1..15
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE
- req_we  in  1  1 = store (sw), 0 = load (lw)
- req_addr  in  32  byte address; word index = req_addr[31:2]
- req_wdata  in  32  store data
- resp_valid  out  1  response present
- resp_ready  in  1  requester takes response
- resp_rdata  out  32  load data; 0 for stores and errored requests
- resp_err  out  1  request rejected (out of range / misaligned)

## Operation
- States: IDLE, WAIT, RESP.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, counter 0. The storage array is not reset.
- IDLE: req_valid && req_ready is the accept. It latches we/addr/wdata. LAT=1 goes to RESP; otherwise it loads the counter with LAT-2 and goes to WAIT.
- WAIT: the counter decrements each cycle. When it is 0, the next edge enters RESP.
- The edge entering RESP does all of the following:
  - commits the write (if we and no error);
  - samples read data (if !we and no error);
  - sets resp_valid=1;
  - sets resp_err.
- RESP: resp_valid, resp_rdata and resp_err are held stable until resp_valid && resp_ready. That edge clears resp_valid, rdata and err and returns to IDLE.
- Out of range: req_addr[31:2] >= DEPTH gives resp_err=1, no write, resp_rdata=0. There is no wrap-around.
- A read of a word never written returns array content, which is undefined. Benches must not check it.
- Reset asserted in any state returns to IDLE immediately. An uncommitted write (WAIT) is discarded. A committed write persists.

## Timing
- Accept edge at cycle t gives resp_valid high from cycle t+LAT.
- With resp_ready tied high, resp_valid lasts 1 cycle and req_ready is high again at t+LAT+1. Maximum throughput is one request per LAT+1 cycles.
- req_ready is low from the cycle after accept until the cycle after the response handshake.
- A read-after-write to the same address in consecutive requests returns the new data.
- No combinational path from req_* or resp_ready to any output.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: req_addr[1:0] != 0 is an error, with resp_err=1, no write and resp_rdata=0.
- Not defined: req_addr[1:0] is ignored and misaligned addresses access the containing word.

## Structure
- dmem_pkg holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the WORD_BYTES=4 constant;
  - the counter width of 4 bits.
- One sub-module, dmem_array: DEPTH x 32 storage with a synchronous write port and a synchronous read port, both enabled by the RESP-entry strobe.
- dmem_resp holds the FSM, the request latch, the counter and the range/alignment checks.

## Test plan
- LAT=2, store 0xDEADBEEF to 0x10 accepted at cycle 0 -> resp_valid at cycle 2, err=0, rdata=0; then load 0x10 -> rdata=0xDEADBEEF, err=0.
- Load with resp_ready low for 3 cycles -> resp_valid, rdata and err stable, req_ready=0 throughout; resp_ready high -> IDLE, req_ready=1 next cycle.
- DEPTH=1024, store to 0x1000 -> err=1, rdata=0; store 0x12345678 to 0xFFC then load 0xFFC -> 0x12345678, err=0.
- With DMEM_ALIGN_CHECK_EN, store 0xFFFFFFFF to 0x13 -> err=1; load 0x10 -> the prior value 0xDEADBEEF. Without the macro, the same store overwrites word 0x10 and the load returns 0xFFFFFFFF.
- Store 0xAAAA5555 to 0x20 over old 0x11111111, with rst_n pulsed low during WAIT -> outputs at reset values immediately; load 0x20 after release returns 0x11111111.
- LAT=1, back-to-back loads with resp_ready tied high -> resp_valid one cycle after each accept, accepts every 2 cycles.
